// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO stack controller with registered pop data, occupancy
// count, empty/full decodes and sticky overflow/underflow flags.
// Optional feature: define STACK_WMARK_EN to add the wmark output, a
// registered high-water mark of count since reset or clear.
module stack_ctrl #(
  parameter int STACK_WIDTH = 18,
  parameter int STACK_SIZE  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [STACK_WIDTH-1:0] data_in,
  output logic [STACK_WIDTH-1:0] data_out,
  output logic [STACK_SIZE:0]    count,
`ifdef STACK_WMARK_EN
  output logic [STACK_SIZE:0]    wmark,
`endif
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 1 << STACK_SIZE;
  localparam logic [STACK_SIZE:0] FULL_COUNT = {1'b1, {STACK_SIZE{1'b0}}};

  logic [STACK_WIDTH-1:0] mem_q [DEPTH];

  logic [STACK_SIZE:0]    count_q, count_d;
  logic [STACK_WIDTH-1:0] data_out_q, data_out_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
`ifdef STACK_WMARK_EN
  logic [STACK_SIZE:0]    wmark_q, wmark_d;
`endif

  logic                   mem_we;
  logic [STACK_SIZE-1:0]  mem_waddr;
  logic [STACK_SIZE-1:0]  top_idx;
  logic [STACK_WIDTH-1:0] top_data;
  logic                   is_empty, is_full;

  // The pointer is the count itself; top of stack sits one below it.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_COUNT);
  assign top_idx  = STACK_SIZE'(count_q) - STACK_SIZE'(1);
  assign top_data = mem_q[top_idx];

  // Next-state decode of the four push/pop cases, with clear taking priority.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = STACK_SIZE'(count_q);
    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push && pop) begin
      if (is_empty) begin
        data_out_d = data_in;
      end else begin
        data_out_d = top_data;
        mem_we     = 1'b1;
        mem_waddr  = top_idx;
      end
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        mem_we  = 1'b1;
        count_d = count_q + (STACK_SIZE+1)'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        data_out_d = top_data;
        count_d    = count_q - (STACK_SIZE+1)'(1);
      end
    end
  end

`ifdef STACK_WMARK_EN
  // High-water mark follows the registered count, so it lags a rise by one cycle.
  always_comb begin
    wmark_d = wmark_q;
    if (clear) begin
      wmark_d = '0;
    end else if (count_q > wmark_q) begin
      wmark_d = count_q;
    end
  end
`endif

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef STACK_WMARK_EN
      wmark_q     <= '0;
`endif
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef STACK_WMARK_EN
      wmark_q     <= wmark_d;
`endif
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; entries at or above count are never read as valid.
    if (mem_we) begin
      mem_q[mem_waddr] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`ifdef STACK_WMARK_EN
  assign wmark     = wmark_q;
`endif

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The module SHALL have parameter STACK_WIDTH, default 18, as the data word width in bits.
REQ-002 The module SHALL have parameter STACK_SIZE, default 4, as log2 of depth; depth = 2**STACK_SIZE entries.
REQ-003 The module SHALL have port clk  input  1  as the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n  input  1  as the reset, asynchronous and active-low.
REQ-005 The module SHALL have port clear  input  1  as a synchronous empty and error-flag clear.
REQ-006 The module SHALL have port push  input  1  as the request to write data_in on top.
REQ-007 The module SHALL have port pop  input  1  as the request to remove the top entry to data_out.
REQ-008 The module SHALL have port data_in  input  STACK_WIDTH  as the push data.
REQ-009 The module SHALL have port data_out  output  STACK_WIDTH  as the last popped word, registered.
REQ-010 The module SHALL have port count  output  STACK_SIZE+1  as the number of valid entries, 0..2**STACK_SIZE.
REQ-011 The module SHALL have port empty  output  1  asserted when count==0, and port full  output  1  asserted when count==2**STACK_SIZE.
REQ-012 The module SHALL have port overflow  output  1  and port underflow  output  1  as sticky error flags.
REQ-013 With STACK_WMARK_EN defined, the module SHALL have port wmark  output  STACK_SIZE+1  as the high-water mark.

Function
REQ-014 The stack pointer SHALL equal count; push writes mem[count], pop reads mem[count-1]; there SHALL be no modulo wrap of the pointer.
REQ-015 Push only, not full: the module SHALL write data_in at mem[count] and increment count by 1 in the same cycle.
REQ-016 Push only, full: the module SHALL ignore the write, hold count, and set overflow.
REQ-017 Pop only, not empty: the module SHALL load data_out with mem[count-1] and decrement count, with data_out valid 1 cycle after the pop edge.
REQ-018 Pop only, empty: the module SHALL hold data_out and count and set underflow.
REQ-019 Push and pop together, not empty (including full): the module SHALL load data_out with the old top, write data_in to mem[count-1], and hold count, with no error flags set.
REQ-020 Push and pop together, empty: the module SHALL pass through, data_out <= data_in, count stays 0, no flags set, memory unwritten.
REQ-021 empty and full SHALL be combinational decodes of registered count, with no extra latency.
REQ-022 overflow and underflow SHALL remain set until reset or clear.
REQ-023 clear SHALL have priority over push and pop: count <= 0, overflow <= 0, underflow <= 0, data_out held, memory contents untouched.
REQ-024 Memory SHALL be neither reset nor cleared; entries above count are don't-care.

Reset
REQ-025 Asserting reset_n low SHALL immediately set count=0, data_out=0, overflow=0, underflow=0 (and wmark=0 if built), regardless of clk.
REQ-026 Reset mid-operation SHALL abandon any in-flight push or pop; the first operation after release SHALL be on the first rising clk with reset_n high.
REQ-027 The memory array SHALL NOT be reset.

Configuration
REQ-028 The macro STACK_WMARK_EN SHALL control the high-water-mark feature.
REQ-029 With STACK_WMARK_EN defined, wmark SHALL register the maximum count reached since reset or clear, updating the cycle after count rises, and clear SHALL reset it to 0.
REQ-030 With STACK_WMARK_EN undefined, port wmark and its register SHALL be absent, with all other behaviour identical.

Verification (STACK_WIDTH=18, STACK_SIZE=2, depth 4)
REQ-031 The bench SHALL cover: reset, push 0x00011, 0x00022, 0x00033, then three pops -> data_out 0x00033, 0x00022, 0x00011 on successive cycles; count 3->0; empty=1.
REQ-032 The bench SHALL cover: push 5 words 0x1..0x5 from empty -> full=1 after 4th; 5th ignored; overflow=1; pops return 0x4,0x3,0x2,0x1.
REQ-033 The bench SHALL cover: pop on empty after reset -> data_out stays 0, underflow=1, count=0; clear pulse -> underflow=0.
REQ-034 The bench SHALL cover: count=2 (0xA, 0xB), push+pop with data_in 0xC -> data_out=0xB, count=2; next pop -> 0xC.
REQ-035 The bench SHALL cover: push+pop with data_in 0x3FFFF when empty -> data_out=0x3FFFF, count=0, no flags.
REQ-036 The bench SHALL cover: with STACK_WMARK_EN, push 3 then pop 2 -> wmark=3; reset_n low mid-push -> count, data_out, wmark=0 asynchronously.
